// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: payload width, arbiter defaults, index and state types.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_DW   = 8;
  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned GNT_W_DEF = $clog2(N_REQ_DEF);

  typedef logic [GNT_W_DEF-1:0] gnt_idx_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE
  } state_arb_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request searching upward from last_gnt+1, wrapping mod N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_gnt,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // The modulo keeps candidates below N_REQ, so non-power-of-two sizes never yield an out-of-range index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!valid && req[IW'((32'(last_gnt) + k) % N_REQ)]) begin
        valid = 1'b1;
        idx   = IW'((32'(last_gnt) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters with round-robin grants,
// one frame in flight at a time.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = UART_DW,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0][DW-1:0]  data_in,
  output logic [N_REQ-1:0]          ack,
  input  logic                      tx_ready,
  output logic                      tx_start,
  output logic [DW-1:0]             tx_data,
  output logic [IW-1:0]             gnt_id,
  output logic                      busy
);

  state_arb_t       state_q;
  logic [IW-1:0]    last_gnt_q;
  logic [IW-1:0]    gnt_id_q;
  logic [DW-1:0]    tx_data_q;
  logic             tx_start_q;
  logic             busy_q;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             grant_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // A grant happens only from IDLE with the transmitter idle; reset suppresses it outright.
  assign grant_c = (state_q == ARB_IDLE) && tx_ready && pick_valid && !rst;

  always_comb begin
    ack = '0;
    if (grant_c) begin
      ack = N_REQ'(1) << pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= IW'(N_REQ - 1);
      gnt_id_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_c) begin
            state_q    <= ARB_START;
            gnt_id_q   <= pick_idx;
            last_gnt_q <= pick_idx;
            tx_data_q  <= data_in[pick_idx];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ARB_START: begin
          state_q <= ARB_WAIT_BUSY;
        end
        // Wait for the transmitter to acknowledge the frame by dropping its idle flag.
        ARB_WAIT_BUSY: begin
          if (!tx_ready) begin
            state_q <= ARB_WAIT_DONE;
          end
        end
        ARB_WAIT_DONE: begin
          if (tx_ready) begin
            state_q <= ARB_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant, handshake, fairness, reset abort, withdrawn request.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0][7:0] data_in;
  logic [3:0]      ack;
  logic            tx_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [1:0]      gnt_id;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // From START with tx_ready high: run one transmitter frame back to IDLE.
  task automatic finish_frame(input string tag);
    tick();
    chk({tag, "_start_one_cycle"}, 32'(tx_start), 32'd0);
    tx_ready = 1'b0;
    tick();
    chk({tag, "_no_ack_in_frame"}, 32'(ack), 32'd0);
    tx_ready = 1'b1;
    tick();
    chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b0000;
    tx_ready = 1'b1;
    data_in[0] = 8'h11;
    data_in[1] = 8'h22;
    data_in[2] = 8'hA5;
    data_in[3] = 8'h44;
    tick();
    tick();
    chk("rst_ack",      32'(ack),      32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_gnt_id",   32'(gnt_id),   32'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 2, then the ready handshake.
    req = 4'b0100;
    settle();
    chk("single_ack", 32'(ack), 32'h4);
    tick();
    req = 4'b0000;
    chk("single_ack_pulse", 32'(ack),      32'd0);
    chk("single_tx_start",  32'(tx_start), 32'd1);
    chk("single_tx_data",   32'(tx_data),  32'hA5);
    chk("single_gnt_id",    32'(gnt_id),   32'd2);
    chk("single_busy",      32'(busy),     32'd1);
    tick();
    chk("single_start_drop", 32'(tx_start), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hs_hold_wait_busy", 32'(dut.state_q), 32'(ARB_WAIT_BUSY));
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 86; i++) begin
      tick();
    end
    chk("hs_wait_done", 32'(dut.state_q), 32'(ARB_WAIT_DONE));
    chk("hs_busy_mid",  32'(busy),        32'd1);
    chk("hs_data_held", 32'(tx_data),     32'hA5);
    tx_ready = 1'b1;
    tick();
    chk("hs_idle",      32'(dut.state_q), 32'(ARB_IDLE));
    chk("hs_busy_done", 32'(busy),        32'd0);

    // Transmitter not ready holds off the grant.
    req      = 4'b0001;
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk("nr_no_ack", 32'(ack),  32'd0);
      chk("nr_busy",   32'(busy), 32'd0);
      tick();
    end
    tx_ready = 1'b1;
    settle();
    chk("nr_ack_same_cycle", 32'(ack), 32'h1);
    tick();
    req = 4'b0000;
    chk("nr_gnt_id",   32'(gnt_id),   32'd0);
    chk("nr_tx_start", 32'(tx_start), 32'd1);
    chk("nr_tx_data",  32'(tx_data),  32'h11);
    finish_frame("nr");

    // Requester 1 pulses only during WAIT_DONE and must never be acked.
    req = 4'b0100;
    settle();
    chk("wd_ack2", 32'(ack), 32'h4);
    tick();
    req = 4'b0000;
    tick();
    tx_ready = 1'b0;
    tick();
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wd_no_ack_pulse", 32'(ack), 32'd0);
      tick();
    end
    req = 4'b0000;
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wd_no_ack_after", 32'(ack), 32'd0);
    end
    chk("wd_busy", 32'(busy), 32'd0);

    // Reset in WAIT_DONE aborts the frame; next grant searches from requester 0.
    req = 4'b0001;
    settle();
    chk("rm_ack0", 32'(ack), 32'h1);
    tick();
    req = 4'b0000;
    tick();
    tx_ready = 1'b0;
    tick();
    chk("rm_in_wait_done", 32'(dut.state_q), 32'(ARB_WAIT_DONE));
    req = 4'b1000;
    rst = 1'b1;
    settle();
    chk("rm_ack_during_rst", 32'(ack), 32'd0);
    tick();
    chk("rm_tx_start", 32'(tx_start), 32'd0);
    chk("rm_tx_data",  32'(tx_data),  32'd0);
    chk("rm_busy",     32'(busy),     32'd0);
    chk("rm_gnt_id",   32'(gnt_id),   32'd0);
    rst      = 1'b0;
    tx_ready = 1'b1;
    settle();
    chk("rm_first_ack", 32'(ack), 32'h8);
    tick();
    req = 4'b0000;
    chk("rm_first_gnt", 32'(gnt_id),   32'd3);
    chk("rm_first_tx",  32'(tx_data),  32'h44);
    chk("rm_first_st",  32'(tx_start), 32'd1);
    finish_frame("rm");

    // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
    req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      settle();
      chk("fair_ack", 32'(ack), 32'(4'b0001 << (f % 4)));
      tick();
      chk("fair_gnt_id",   32'(gnt_id),   32'(f % 4));
      chk("fair_tx_start", 32'(tx_start), 32'd1);
      chk("fair_tx_data",  32'(tx_data),  32'(data_in[f % 4]));
      finish_frame("fair");
    end
    req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
